// File: rtl/score_render.sv
// Draws the 4-digit packed-BCD score as 5x7 glyphs on the raster, one snapshot per frame,
// with a blinking freeze of the display whenever the score crosses a 100-point milestone.
module score_render #(
  parameter int X0           = 560,
  parameter int Y0           = 16,
  parameter int SCALE_LOG2   = 1,
  parameter int FLASH_FRAMES = 8,
  parameter int LZ_BLANK     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_tick,
  input  logic        game_start,
  input  logic        game_over,
  input  logic [15:0] score,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output logic        pixel_on,
  output logic        flashing
);

  localparam int S   = 1 << SCALE_LOG2;
  localparam int SW  = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int FCW = $clog2(6 * FLASH_FRAMES);
  localparam logic [9:0]     X_LO    = 10'(X0);
  localparam logic [9:0]     X_HI    = 10'(X0 + 24 * S);
  localparam logic [9:0]     Y_LO    = 10'(Y0);
  localparam logic [9:0]     Y_HI    = 10'(Y0 + 7 * S);
  localparam logic [SW-1:0]  SUB_MAX = SW'(S - 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(6 * FLASH_FRAMES - 1);

  typedef enum logic {NORMAL, FLASH} state_t;

  state_t         state_q, state_d;
  logic [15:0]    snap_q, snap_d, freeze_q, freeze_d;
  logic [FCW-1:0] fc_q, fc_d, fc_div;
  logic           trk_q, trk_d;
  logic [SW-1:0]  sub_q, sub_d;
  logic [2:0]     col_q, col_d;
  logic [1:0]     dig_q, dig_d;
  logic           pixel_on_q, pixel_on_d, flashing_q, flashing_d;

  logic           milestone;
  logic           x_in, y_in, load;
  logic           cur_trk;
  logic [SW-1:0]  cur_sub;
  logic [2:0]     cur_col, row;
  logic [1:0]     cur_dig;
  logic [9:0]     dy;
  logic [15:0]    disp;
  logic [3:0]     nib;
  logic [4:0]     row_bits;
  logic           flash_off, lead_zero, blank;

  function automatic logic [4:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [34:0] g;
    case (d)
      4'd0:    g = 35'b01110_10001_10011_10101_11001_10001_01110;
      4'd1:    g = 35'b00100_01100_00100_00100_00100_00100_01110;
      4'd2:    g = 35'b01110_10001_00001_00010_00100_01000_11111;
      4'd3:    g = 35'b11111_00010_00100_00010_00001_10001_01110;
      4'd4:    g = 35'b00010_00110_01010_10010_11111_00010_00010;
      4'd5:    g = 35'b11111_10000_11110_00001_00001_10001_01110;
      4'd6:    g = 35'b00110_01000_10000_11110_10001_10001_01110;
      4'd7:    g = 35'b11111_00001_00010_00100_01000_01000_01000;
      4'd8:    g = 35'b01110_10001_10001_01110_10001_10001_01110;
      4'd9:    g = 35'b01110_10001_10001_01111_00001_00010_01100;
      default: g = '0;
    endcase
    case (r)
      3'd0:    return g[34:30];
      3'd1:    return g[29:25];
      3'd2:    return g[24:20];
      3'd3:    return g[19:15];
      3'd4:    return g[14:10];
      3'd5:    return g[9:5];
      3'd6:    return g[4:0];
      default: return 5'b0;
    endcase
  endfunction

  // Snapshot and flash FSM: game_over/game_start override any milestone on the same clk.
  always_comb begin
    snap_d    = game_tick ? score : snap_q;
    state_d   = state_q;
    fc_d      = fc_q;
    freeze_d  = freeze_q;
    milestone = game_tick && (score[7:0] == 8'h00) && (score != snap_q) && (score != 16'h0);
    if (game_over || game_start) begin
      state_d = NORMAL;
      fc_d    = '0;
    end else if (milestone) begin
      state_d  = FLASH;
      fc_d     = '0;
      freeze_d = score;
    end else if ((state_q == FLASH) && game_tick) begin
      if (fc_q == FC_LAST) begin
        state_d = NORMAL;
        fc_d    = '0;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
    flashing_d = (state_d == FLASH);
  end

  // Column tracking: hpos==X0 loads the counters combinationally so the first glyph column
  // is usable on the same clk, keeping a single cycle of latency to pixel_on.
  always_comb begin
    x_in    = (hpos >= X_LO) && (hpos < X_HI);
    y_in    = (vpos >= Y_LO) && (vpos < Y_HI);
    load    = (hpos == X_LO) && y_in;
    cur_trk = load || trk_q;
    cur_sub = load ? '0 : sub_q;
    cur_col = load ? 3'd0 : col_q;
    cur_dig = load ? 2'd3 : dig_q;
    trk_d   = cur_trk;
    sub_d   = cur_sub;
    col_d   = cur_col;
    dig_d   = cur_dig;
    if (cur_trk) begin
      if (cur_sub == SUB_MAX) begin
        sub_d = '0;
        if (cur_col == 3'd5) begin
          col_d = 3'd0;
          if (cur_dig == 2'd0) trk_d = 1'b0;
          else                 dig_d = cur_dig - 2'd1;
        end else begin
          col_d = cur_col + 3'd1;
        end
      end else begin
        sub_d = cur_sub + 1'b1;
      end
    end
  end

  always_comb begin
    dy         = vpos - Y_LO;
    row        = 3'(dy >> SCALE_LOG2);
    disp       = (state_q == FLASH) ? freeze_q : snap_q;
    nib        = disp[{cur_dig, 2'b00} +: 4];
    fc_div     = fc_q / FCW'(FLASH_FRAMES);
    flash_off  = (state_q == FLASH) && fc_div[0];
    lead_zero  = (LZ_BLANK != 0) && (cur_dig != 2'd0) && ((disp >> {cur_dig, 2'b00}) == 16'h0);
    blank      = flash_off || (nib > 4'h9) || lead_zero;
    row_bits   = font_row(nib, row);
    pixel_on_d = x_in && y_in && cur_trk && (cur_col < 3'd5) && !blank &&
                 row_bits[3'd4 - cur_col];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NORMAL;
      snap_q     <= 16'h0;
      freeze_q   <= 16'h0;
      fc_q       <= '0;
      trk_q      <= 1'b0;
      sub_q      <= '0;
      col_q      <= 3'd0;
      dig_q      <= 2'd0;
      pixel_on_q <= 1'b0;
      flashing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      freeze_q   <= freeze_d;
      fc_q       <= fc_d;
      trk_q      <= trk_d;
      sub_q      <= sub_d;
      col_q      <= col_d;
      dig_q      <= dig_d;
      pixel_on_q <= pixel_on_d;
      flashing_q <= flashing_d;
    end
  end

  assign pixel_on = pixel_on_q;
  assign flashing = flashing_q;

endmodule

// File: tb/tb_score_render.sv
// Bench for score_render: table of score/tick vectors plus hand sequences for flash timing,
// abort paths and mid-line reset; pixels checked against a divider-based raster model.
module tb_score_render;

  localparam int X0 = 560;
  localparam int Y0 = 16;

  localparam logic [4:0] FONT [10][7] = '{
    '{5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110},
    '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110},
    '{5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111},
    '{5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110},
    '{5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010},
    '{5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110},
    '{5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110},
    '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000},
    '{5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110},
    '{5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100}
  };

  typedef struct {
    logic [15:0] score;
    bit          do_tick;
    logic [15:0] exp_disp;
    bit          exp_flash;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, game_tick, game_start, game_over;
  logic [15:0] score;
  logic [9:0]  hpos, vpos;
  logic        pixel_on, flashing, pixel_on_lz, flashing_lz;

  logic [0:0]  exp_q[$];
  logic [0:0]  exp_lz_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  vec_t        vecs[10];

  score_render u_dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .game_start(game_start),
    .game_over(game_over), .score(score), .hpos(hpos), .vpos(vpos),
    .pixel_on(pixel_on), .flashing(flashing)
  );

  score_render #(.LZ_BLANK(1)) u_lz (
    .clk(clk), .rst(rst), .game_tick(game_tick), .game_start(game_start),
    .game_over(game_over), .score(score), .hpos(hpos), .vpos(vpos),
    .pixel_on(pixel_on_lz), .flashing(flashing_lz)
  );

  always #5 clk = ~clk;

  function automatic bit model_pix(input logic [15:0] disp, input int h, input int v,
                                   input bit off, input bit lz);
    int dx, dy, c, dg;
    logic [3:0] nb;
    logic [4:0] rb;
    dx = h - X0;
    dy = v - Y0;
    if (dx < 0 || dx >= 48 || dy < 0 || dy >= 14 || off) return 1'b0;
    c = (dx % 12) / 2;
    if (c >= 5) return 1'b0;
    dg = 3 - dx / 12;
    nb = disp[4*dg +: 4];
    if (nb > 4'h9) return 1'b0;
    if (lz && dg > 0 && (disp >> (4 * dg)) == 16'h0) return 1'b0;
    rb = FONT[int'(nb)][dy / 2];
    return rb[4 - c];
  endfunction

  task automatic chk(input string nm, input logic got, input logic exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask

  task automatic step(input int h, input int v, input logic [15:0] disp, input bit off);
    logic [0:0] e, e_lz;
    hpos = 10'(h);
    vpos = 10'(v);
    exp_q.push_back(model_pix(disp, h, v, off, 1'b0));
    exp_lz_q.push_back(model_pix(disp, h, v, off, 1'b1));
    @(posedge clk);
    @(negedge clk);
    e    = exp_q.pop_front();
    e_lz = exp_lz_q.pop_front();
    chk($sformatf("pix h=%0d v=%0d", h, v), pixel_on, e);
    chk($sformatf("pix_lz h=%0d v=%0d", h, v), pixel_on_lz, e_lz);
  endtask

  task automatic scan_row(input int v, input logic [15:0] disp, input bit off);
    for (int h = X0 - 3; h <= X0 + 50; h++) step(h, v, disp, off);
  endtask

  task automatic scan_frame(input logic [15:0] disp, input bit off);
    for (int v = Y0 - 1; v <= Y0 + 14; v++) scan_row(v, disp, off);
  endtask

  task automatic tick();
    hpos = 10'd0;
    vpos = 10'd0;
    game_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    game_tick = 1'b0;
  endtask

  task automatic pulse_over();
    game_over = 1'b1;
    @(posedge clk);
    @(negedge clk);
    game_over = 1'b0;
  endtask

  task automatic chk_flash(input string nm, input logic exp);
    chk(nm, flashing, exp);
    chk({nm, "_lz"}, flashing_lz, exp);
  endtask

  initial begin
    vecs[0] = '{16'h0041, 1'b1, 16'h0041, 1'b0};
    vecs[1] = '{16'h0057, 1'b0, 16'h0041, 1'b0};
    vecs[2] = '{16'h0057, 1'b1, 16'h0057, 1'b0};
    vecs[3] = '{16'h1234, 1'b1, 16'h1234, 1'b0};
    vecs[4] = '{16'h00A3, 1'b1, 16'h00A3, 1'b0};
    vecs[5] = '{16'h0007, 1'b1, 16'h0007, 1'b0};
    vecs[6] = '{16'h9999, 1'b1, 16'h9999, 1'b0};
    vecs[7] = '{16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[8] = '{16'h0099, 1'b1, 16'h0099, 1'b0};
    vecs[9] = '{16'h0100, 1'b1, 16'h0100, 1'b1};

    rst = 1'b1; game_tick = 1'b0; game_start = 1'b0; game_over = 1'b0;
    score = 16'h0; hpos = 10'd0; vpos = 10'd0;
    repeat (3) @(negedge clk);
    chk("reset_pixel", pixel_on, 1'b0);
    chk("reset_pixel_lz", pixel_on_lz, 1'b0);
    chk_flash("reset_flashing", 1'b0);
    rst = 1'b0;
    scan_frame(16'h0000, 1'b0);

    for (int i = 0; i < 10; i++) begin
      score = vecs[i].score;
      if (vecs[i].do_tick) tick();
      chk_flash($sformatf("vec%0d_flashing", i), vecs[i].exp_flash);
      scan_frame(vecs[i].exp_disp, 1'b0);
    end

    // Full flash: frozen at 0100 while snap moves to 0150; blank on odd eighths.
    score = 16'h0150;
    for (int f = 1; f <= 47; f++) begin
      tick();
      chk_flash($sformatf("flash_f%0d", f), 1'b1);
      scan_row(Y0 + 2, 16'h0100, ((f / 8) % 2) == 1);
    end
    tick();
    chk_flash("flash_exit", 1'b0);
    scan_frame(16'h0150, 1'b0);

    // game_over during the off interval at frame 10.
    score = 16'h0200;
    tick();
    chk_flash("flash2_entry", 1'b1);
    score = 16'h0250;
    for (int f = 1; f <= 10; f++) tick();
    scan_row(Y0 + 2, 16'h0200, 1'b1);
    pulse_over();
    chk_flash("over_abort", 1'b0);
    scan_frame(16'h0250, 1'b0);

    // Milestone tick together with game_over.
    score = 16'h0300;
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    chk_flash("tick_over_same", 1'b0);
    scan_frame(16'h0300, 1'b0);

    // game_start aborts too.
    score = 16'h0400;
    tick();
    chk_flash("flash3_entry", 1'b1);
    game_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    game_start = 1'b0;
    chk_flash("start_abort", 1'b0);
    scan_row(Y0 + 2, 16'h0400, 1'b0);

    // Milestone inside a flash restarts it visible with the new freeze.
    score = 16'h0500;
    tick();
    score = 16'h0550;
    for (int f = 1; f <= 9; f++) tick();
    scan_row(Y0 + 2, 16'h0500, 1'b1);
    score = 16'h0600;
    tick();
    chk_flash("restart", 1'b1);
    scan_row(Y0 + 2, 16'h0600, 1'b0);

    // Mid-line reset while a glyph pixel is lit and the flash is active.
    for (int h = X0 - 3; h <= X0 + 4; h++) step(h, Y0, 16'h0600, 1'b0);
    rst = 1'b1;
    #1;
    chk("midline_rst_pixel", pixel_on, 1'b0);
    chk("midline_rst_pixel_lz", pixel_on_lz, 1'b0);
    chk_flash("midline_rst_flashing", 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    score = 16'h0000;
    tick();
    chk_flash("post_rst", 1'b0);
    scan_frame(16'h0000, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
